// File: rtl/valve_pkg.sv
// Shared state encodings and helpers for the irrigation valve driver.
package valve_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_OPENING = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUNNING = 3'd2;
    localparam logic [STATE_W-1:0] ST_CLOSING = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLDOFF = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT   = 3'd5;

    function automatic logic valve_on(input logic [STATE_W-1:0] st);
        return (st == ST_OPENING) || (st == ST_RUNNING) || (st == ST_CLOSING);
    endfunction

endpackage

// File: rtl/valve_driver_if.sv
// Controller-facing bundle of the valve driver: request/ack inputs and drive/status outputs.
interface valve_driver_if
    import valve_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic                water_toggle;
    logic                flow_pulse;
    logic                fault_clear;
    logic                valve_open;
    logic                pump_en;
    logic                busy;
    logic                fault;
    logic                timeout;
    logic [CNT_W-1:0]    flow_count;
    logic [STATE_W-1:0]  state;

    modport master (
        output water_toggle, flow_pulse, fault_clear,
        input  valve_open, pump_en, busy, fault, timeout, flow_count, state
    );

    modport slave (
        input  water_toggle, flow_pulse, fault_clear,
        output valve_open, pump_en, busy, fault, timeout, flow_count, state
    );
endinterface

// File: rtl/valve_driver_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector; pulse is high for one clk cycle per input edge.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic sync1_reg, sync2_reg, prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;
endmodule

// File: rtl/valve_driver.sv
// Valve/pump sequencer with min/max on-time, hold-off and watchdog.
// Define FLOW_CHECK_EN to enable flow-pulse counting and the no-flow fault.
module valve_driver
    import valve_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int OPEN_DELAY     = 4,
    parameter int CLOSE_DELAY    = 4,
    parameter int MIN_ON_CYCLES  = 8,
    parameter int MAX_ON_CYCLES  = 255,
    parameter int MIN_OFF_CYCLES = 16,
    parameter int FLOW_TIMEOUT   = 32
) (
    input  logic          clk,
    input  logic          rst,
    valve_driver_if.slave bus
);
    // Timers count from 0 at state entry, so a state of N cycles exits when the timer reads N-1.
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_DELAY - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_DELAY - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [CNT_W-1:0]   tmr_reg;
    logic               timeout_reg, timeout_next;
    logic               valve_open_reg, pump_en_reg;
    logic               flow_stall;

    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.water_toggle) begin
                    state_next   = ST_OPENING;
                    timeout_next = 1'b0;
                end
            end
            ST_OPENING: if (tmr_reg >= OPEN_LAST) state_next = ST_RUNNING;
            ST_RUNNING: begin
                // Priority: no-flow fault, then watchdog, then normal close.
                if (flow_stall) begin
                    state_next = ST_FAULT;
                end else if (tmr_reg >= MAX_LAST) begin
                    state_next   = ST_CLOSING;
                    timeout_next = 1'b1;
                end else if (!bus.water_toggle && (tmr_reg >= MIN_LAST)) begin
                    state_next = ST_CLOSING;
                end
            end
            ST_CLOSING: if (tmr_reg >= CLOSE_LAST) state_next = ST_HOLDOFF;
            ST_HOLDOFF: if (tmr_reg >= OFF_LAST) state_next = ST_IDLE;
            ST_FAULT:   if (bus.fault_clear) state_next = ST_HOLDOFF;
            default:    state_next = ST_IDLE;
        endcase
        if (bus.fault_clear) timeout_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tmr_reg        <= '0;
            timeout_reg    <= 1'b0;
            valve_open_reg <= 1'b0;
            pump_en_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timeout_reg    <= timeout_next;
            valve_open_reg <= valve_on(state_next);
            pump_en_reg    <= (state_next == ST_RUNNING);
            if (state_next != state_reg) tmr_reg <= '0;
            else if (tmr_reg != '1)      tmr_reg <= tmr_reg + CNT_ONE;
        end
    end

`ifdef FLOW_CHECK_EN
    localparam logic [CNT_W-1:0] FLOW_LAST = CNT_W'(FLOW_TIMEOUT - 1);

    logic             flow_edge;
    logic [CNT_W-1:0] flow_count_reg, flow_tmr_reg;

    pulse_sync u_flow_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.flow_pulse),
        .pulse (flow_edge)
    );

    assign flow_stall = (flow_tmr_reg >= FLOW_LAST) && !flow_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flow_count_reg <= '0;
            flow_tmr_reg   <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && (state_next == ST_OPENING))
                flow_count_reg <= '0;
            else if ((state_reg == ST_RUNNING) && flow_edge && (flow_count_reg != '1))
                flow_count_reg <= flow_count_reg + CNT_ONE;
            // Holding at zero outside RUNNING gives a fresh window at RUNNING entry.
            if ((state_reg != ST_RUNNING) || flow_edge) flow_tmr_reg <= '0;
            else if (flow_tmr_reg != '1)                flow_tmr_reg <= flow_tmr_reg + CNT_ONE;
        end
    end

    assign bus.flow_count = flow_count_reg;
    assign bus.fault      = (state_reg == ST_FAULT);
`else
    logic unused_flow;
    assign unused_flow    = bus.flow_pulse | (FLOW_TIMEOUT == 0);
    assign flow_stall     = 1'b0;
    assign bus.flow_count = '0;
    assign bus.fault      = 1'b0;
`endif

    assign bus.valve_open = valve_open_reg;
    assign bus.pump_en    = pump_en_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.timeout    = timeout_reg;
    assign bus.state      = state_reg;
endmodule

// File: doc/valve_driver.md
VALVE_DRIVER -- requirements
Module: valve_driver

Interface
REQ-001 Parameter CNT_W, 8: width of all internal timers and of flow_count.
REQ-002 Parameter OPEN_DELAY, 4: cycles the valve is open before the pump starts.
REQ-003 Parameter CLOSE_DELAY, 4: cycles the valve stays open after the pump stops.
REQ-004 Parameter MIN_ON_CYCLES, 8: minimum pump-on time per watering.
REQ-005 Parameter MAX_ON_CYCLES, 255: watchdog limit on pump-on time.
REQ-006 Parameter MIN_OFF_CYCLES, 16: hold-off after every close before a new request is accepted.
REQ-007 Parameter FLOW_TIMEOUT, 32: maximum cycles between flow pulses while pumping.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous and active-high.
REQ-010 water_toggle  in  1  watering request, level, from the irrigation controller.
REQ-011 flow_pulse  in  1  asynchronous flow-meter pulse.
REQ-012 fault_clear  in  1  single-cycle fault and timeout acknowledge.
REQ-013 valve_open  out  1  valve solenoid drive, registered.
REQ-014 pump_en  out  1  pump drive, registered.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 fault  out  1  high only in FAULT.
REQ-017 timeout  out  1  sticky flag: last run was ended by the watchdog.
REQ-018 flow_count  out  CNT_W  flow pulses counted in the current or last run.
REQ-019 state  out  3  current state encoding.

Function
REQ-020 States: IDLE=0, OPENING=1, RUNNING=2, CLOSING=3, HOLDOFF=4, FAULT=5; no other encodings are reachable.
REQ-021 Outputs: valve_open=1 in OPENING, RUNNING and CLOSING only; pump_en=1 in RUNNING only; the pump is never on with the valve closed.
REQ-022 IDLE with water_toggle=1 at a rising edge -> OPENING on that edge; this clears timeout and flow_count.
REQ-023 OPENING lasts exactly OPEN_DELAY cycles, then goes to RUNNING regardless of water_toggle.
REQ-024 RUNNING -> CLOSING when water_toggle=0 and on-time >= MIN_ON_CYCLES; a request drop before that point is held until MIN_ON_CYCLES is reached.
REQ-025 RUNNING -> CLOSING with timeout set when on-time reaches MAX_ON_CYCLES, even if water_toggle=1.
REQ-026 CLOSING lasts exactly CLOSE_DELAY cycles, then goes to HOLDOFF.
REQ-027 HOLDOFF lasts exactly MIN_OFF_CYCLES cycles with water_toggle ignored, then goes to IDLE; a request still high then starts OPENING one cycle later.
REQ-028 Timers reset on state entry, saturate, and never wrap.
REQ-029 flow_count counts synchronized flow_pulse rising edges in RUNNING only and saturates at all-ones.
REQ-030 FAULT: valve and pump are off; FAULT is left only on fault_clear=1, going to HOLDOFF; fault_clear also clears timeout in any state.
REQ-031 Simultaneous events: FAULT has priority over the watchdog, and the watchdog has priority over a normal close.

Reset
REQ-032 rst=1 forces IDLE, valve_open=0, pump_en=0, busy=0, fault=0, timeout=0, flow_count=0, with all timers and synchronizer stages cleared, immediately and asynchronously, including in mid-run.
REQ-033 After rst deasserts, the first request is accepted on the first rising edge; no hold-off applies.

Configuration
REQ-034 Macro FLOW_CHECK_EN defined: flow_pulse is synchronized, counted, and checked.
REQ-035 With FLOW_CHECK_EN defined: RUNNING goes to FAULT when FLOW_TIMEOUT cycles pass with no flow edge; the flow timer restarts at RUNNING entry and at every edge.
REQ-036 FLOW_CHECK_EN undefined: flow_pulse is unused, flow_count is tied to 0, fault is tied to 0, and FAULT is unreachable.

Structure
REQ-037 Shared package valve_pkg holds the state encodings and the 3-bit state width constant.
REQ-038 Sub-module pulse_sync holds a two-flop synchronizer and a rising-edge detector with a single-cycle pulse output; it is instantiated only under FLOW_CHECK_EN.

Verification
REQ-039 Defaults: water_toggle=1 for 40 cycles -> valve_open on edge 1, pump_en on edge 5, pump_en off after on-time >= 8, valve closes 4 cycles later, busy stays high 16 more cycles.
REQ-040 water_toggle pulsed high for 1 cycle -> full sequence runs with exactly 8 pump cycles and no early close.
REQ-041 MAX_ON_CYCLES=20, water_toggle held high -> pump off after 20 cycles, timeout=1, timeout cleared by the next OPENING.
REQ-042 FLOW_CHECK_EN, pulses every 10 cycles, then none -> flow_count increments per pulse; FAULT 32 cycles after the last pulse, outputs off; fault_clear -> HOLDOFF -> IDLE.
REQ-043 rst asserted in RUNNING -> valve_open and pump_en drop with no clock edge; request re-asserted after release -> OPENING on the first edge.
REQ-044 Request re-asserted during HOLDOFF -> ignored until HOLDOFF expires, then OPENING on the following edge.
